// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multi-cycle MIPS control sequencer.
// Moves each instruction through FETCH/DECODE/EXEC/MEM/WB and handshakes with
// variable-latency instruction and data memories. Illegal opcodes and memory
// timeouts send it to a sticky TRAP state that only rst can leave. It also
// counts retired instructions.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   run                           permit a new fetch (sampled in FETCH only)
//   opcode, funct                 IR[31:26], IR[5:0]
//   condZero                      ALU zero flag, used by beq/bne in EXEC
//   imem_ready, dmem_ready        memory completion
//   imem_req, dmem_req            memory requests
//   ir_write, pc_write, PCSrc     IR load, PC update and PC source select
//   regDst, regWrite, memToReg    register-file write controls
//   ALUSrc, ALUOp                 ALU operand select and operation
//   memWrite, mem_size, mem_signed  data-memory access controls
//   trap                          sticky error flag
//   retired                       retired-instruction count (wraps)
module mc_control_fsm #(
  parameter int unsigned ALUOP_W     = 4,
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter bit          SIGNED_LD   = 1'b0,
  parameter int unsigned RET_W       = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               condZero,
  input  logic               imem_ready,
  input  logic               dmem_ready,
  output logic               imem_req,
  output logic               dmem_req,
  output logic               ir_write,
  output logic               pc_write,
  output logic [1:0]         PCSrc,
  output logic [1:0]         regDst,
  output logic               regWrite,
  output logic               ALUSrc,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               memWrite,
  output logic [1:0]         memToReg,
  output logic [1:0]         mem_size,
  output logic               mem_signed,
  output logic               trap,
  output logic [RET_W-1:0]   retired
);

  localparam int unsigned WAIT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    WAIT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  typedef enum logic [2:0] {
    C_ALU, C_LOAD, C_STORE, C_BEQ, C_BNE, C_J, C_JAL, C_JR
  } cls_t;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0001, OP_XOR = 4'b0010, OP_OR  = 4'b0011,
    OP_ADD  = 4'b0101, OP_SUB = 4'b0110, OP_SLTU = 4'b1000,
    OP_SLT  = 4'b1001, OP_SLL = 4'b1010, OP_SRL = 4'b1011,
    OP_LUI  = 4'b1100
  } aluop_t;

  typedef struct packed {
    cls_t       cls;
    logic       rtype;
    aluop_t     aluop;
    logic       alusrc;
    logic [1:0] size;
    logic       sgn;
  } dec_t;

  state_t            state;
  dec_t              dec, dec_c;
  logic              legal;
  logic [WAIT_W-1:0] wait_cnt;
  logic              timeout;
  logic [3:0]        alu_code;

  assign timeout = (TIMEOUT_CYC != 0) && (wait_cnt == WAIT_LAST);
  assign ALUOp   = ALUOP_W'(alu_code);

  // Instruction decode; captured into dec during DECODE so EXEC/MEM/WB do not
  // depend on the IR after that point.
  always_comb begin
    dec_c.cls    = C_ALU;
    dec_c.rtype  = 1'b0;
    dec_c.aluop  = OP_ADD;
    dec_c.alusrc = 1'b1;
    dec_c.size   = 2'b00;
    dec_c.sgn    = 1'b0;
    legal        = 1'b1;
    case (opcode)
      6'b000000: begin
        dec_c.rtype  = 1'b1;
        dec_c.alusrc = 1'b0;
        case (funct)
          6'b100000, 6'b100001: dec_c.aluop = OP_ADD;
          6'b100010, 6'b100011: dec_c.aluop = OP_SUB;
          6'b100100: dec_c.aluop = OP_AND;
          6'b100101: dec_c.aluop = OP_OR;
          6'b100110: dec_c.aluop = OP_XOR;
          6'b101010: dec_c.aluop = OP_SLT;
          6'b101011: dec_c.aluop = OP_SLTU;
          6'b000000: dec_c.aluop = OP_SLL;
          6'b000010: dec_c.aluop = OP_SRL;
          6'b001000: dec_c.cls   = C_JR;
          default:   legal       = 1'b0;
        endcase
      end
      6'b001000, 6'b001001: dec_c.aluop = OP_ADD;
      6'b001100: dec_c.aluop = OP_AND;
      6'b001101: dec_c.aluop = OP_OR;
      6'b001010: dec_c.aluop = OP_SLT;
      6'b001011: dec_c.aluop = OP_SLTU;
      6'b001111: dec_c.aluop = OP_LUI;
      6'b000100: begin dec_c.cls = C_BEQ; dec_c.aluop = OP_SUB; dec_c.alusrc = 1'b0; end
      6'b000101: begin dec_c.cls = C_BNE; dec_c.aluop = OP_SUB; dec_c.alusrc = 1'b0; end
      6'b100011: dec_c.cls = C_LOAD;
      6'b100100: begin dec_c.cls = C_LOAD; dec_c.size = 2'b10; end
      6'b100101: begin dec_c.cls = C_LOAD; dec_c.size = 2'b01; end
      6'b100000: begin
        dec_c.cls = C_LOAD; dec_c.size = 2'b10; dec_c.sgn = 1'b1; legal = SIGNED_LD;
      end
      6'b100001: begin
        dec_c.cls = C_LOAD; dec_c.size = 2'b01; dec_c.sgn = 1'b1; legal = SIGNED_LD;
      end
      6'b101011: dec_c.cls = C_STORE;
      6'b101000: begin dec_c.cls = C_STORE; dec_c.size = 2'b10; end
      6'b101001: begin dec_c.cls = C_STORE; dec_c.size = 2'b01; end
      6'b000010: begin dec_c.cls = C_J;   dec_c.alusrc = 1'b0; end
      6'b000011: begin dec_c.cls = C_JAL; dec_c.alusrc = 1'b0; end
      default:   legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      dec      <= '0;
      wait_cnt <= '0;
      retired  <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (run) begin
            if (imem_ready)   state    <= S_DECODE;
            else if (timeout) state    <= S_TRAP;
            else              wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_DECODE: begin
          dec   <= dec_c;
          state <= legal ? S_EXEC : S_TRAP;
        end
        S_EXEC: begin
          case (dec.cls)
            C_ALU: state <= S_WB;
            C_LOAD, C_STORE: begin
              state    <= S_MEM;
              wait_cnt <= '0;
            end
            default: begin
              state    <= S_FETCH;
              wait_cnt <= '0;
              retired  <= retired + 1'b1;
            end
          endcase
        end
        S_MEM: begin
          if (dmem_ready) begin
            if (dec.cls == C_STORE) begin
              state    <= S_FETCH;
              wait_cnt <= '0;
              retired  <= retired + 1'b1;
            end else begin
              state <= S_WB;
            end
          end else if (timeout) begin
            state <= S_TRAP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_WB: begin
          state    <= S_FETCH;
          wait_cnt <= '0;
          retired  <= retired + 1'b1;
        end
        default: state <= S_TRAP;
      endcase
    end
  end

  // Mealy terms (fetch handshake, branch condition) are combined with the
  // registered state here; everything is forced low while rst is asserted.
  always_comb begin
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    PCSrc      = 2'b00;
    regDst     = 2'b00;
    regWrite   = 1'b0;
    ALUSrc     = 1'b0;
    alu_code   = '0;
    memWrite   = 1'b0;
    memToReg   = 2'b00;
    mem_size   = 2'b00;
    mem_signed = 1'b0;
    trap       = 1'b0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          imem_req = run;
          if (run && imem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
          end
        end
        S_EXEC: begin
          alu_code = dec.aluop;
          ALUSrc   = dec.alusrc;
          case (dec.cls)
            C_BEQ: begin pc_write = condZero;  PCSrc = 2'b11; end
            C_BNE: begin pc_write = !condZero; PCSrc = 2'b11; end
            C_J:   begin pc_write = 1'b1;      PCSrc = 2'b01; end
            C_JR:  begin pc_write = 1'b1;      PCSrc = 2'b10; end
            C_JAL: begin
              pc_write = 1'b1;
              PCSrc    = 2'b01;
              regWrite = 1'b1;
              regDst   = 2'b10;
              memToReg = 2'b10;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          dmem_req   = 1'b1;
          memWrite   = (dec.cls == C_STORE);
          mem_size   = dec.size;
          mem_signed = dec.sgn;
          alu_code   = OP_ADD;
          ALUSrc     = 1'b1;
        end
        S_WB: begin
          regWrite = 1'b1;
          regDst   = dec.rtype ? 2'b01 : 2'b00;
          memToReg = (dec.cls == C_LOAD) ? 2'b01 : 2'b00;
          alu_code = dec.aluop;
          ALUSrc   = dec.alusrc;
        end
        S_TRAP: trap = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: bench for mc_control_fsm with SIGNED_LD=1, TIMEOUT_CYC=16.
// Memory responders answer after a programmable number of wait cycles; each
// issued instruction pushes its expected per-instruction activity summary and a
// monitor pops and compares it when the retire counter moves.
module tb_mc_control_fsm;

  logic        clk = 1'b0;
  logic        rst, run, condZero, imem_ready, dmem_ready;
  logic [5:0]  opcode, funct;
  logic        imem_req, dmem_req, ir_write, pc_write, regWrite, ALUSrc;
  logic        memWrite, mem_signed, trap;
  logic [1:0]  PCSrc, regDst, memToReg, mem_size;
  logic [3:0]  ALUOp;
  logic [31:0] retired;

  always #5 clk = ~clk;

  mc_control_fsm #(
    .ALUOP_W(4), .TIMEOUT_CYC(16), .SIGNED_LD(1'b1), .RET_W(32)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .funct(funct),
    .condZero(condZero), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .ir_write(ir_write),
    .pc_write(pc_write), .PCSrc(PCSrc), .regDst(regDst), .regWrite(regWrite),
    .ALUSrc(ALUSrc), .ALUOp(ALUOp), .memWrite(memWrite), .memToReg(memToReg),
    .mem_size(mem_size), .mem_signed(mem_signed), .trap(trap), .retired(retired)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  typedef struct {
    int         lat;
    logic [3:0] aop;
    logic       asrc;
    logic       chk_alu;
    int         nreg;
    logic [1:0] rd;
    logic [1:0] m2r;
    int         npc;
    logic [1:0] pcs;
    int         nmw;
    int         ndr;
    logic [1:0] msz;
    logic       msg;
  } exp_t;

  exp_t  expq[$];
  string tagq[$];

  function automatic exp_t ex(int lat, logic [3:0] aop, logic asrc, logic chk,
                              int nreg, logic [1:0] rd, logic [1:0] m2r,
                              int npc, logic [1:0] pcs, int nmw, int ndr,
                              logic [1:0] msz, logic msg);
    exp_t e;
    e.lat = lat; e.aop = aop; e.asrc = asrc; e.chk_alu = chk;
    e.nreg = nreg; e.rd = rd; e.m2r = m2r; e.npc = npc; e.pcs = pcs;
    e.nmw = nmw; e.ndr = ndr; e.msz = msz; e.msg = msg;
    return e;
  endfunction

  // Latency counted from the first imem_req cycle to the retire cycle inclusive.
  function automatic exp_t alu_e(int iw, logic [3:0] aop, logic asrc, logic [1:0] rd);
    return ex(4 + iw, aop, asrc, 1'b1, 1, rd, 2'b00, 0, 2'b00, 0, 0, 2'b00, 1'b0);
  endfunction
  function automatic exp_t ld_e(int iw, int dw, logic [1:0] msz, logic msg);
    return ex(5 + iw + dw, 4'b0101, 1'b1, 1'b1, 1, 2'b00, 2'b01, 0, 2'b00, 0, dw + 1, msz, msg);
  endfunction
  function automatic exp_t st_e(int iw, int dw, logic [1:0] msz);
    return ex(4 + iw + dw, 4'b0101, 1'b1, 1'b1, 0, 2'b00, 2'b00, 0, 2'b00, dw + 1, dw + 1, msz, 1'b0);
  endfunction
  function automatic exp_t br_e(int iw, logic taken);
    return ex(3 + iw, 4'b0110, 1'b0, 1'b1, 0, 2'b00, 2'b00, taken ? 1 : 0,
              taken ? 2'b11 : 2'b00, 0, 0, 2'b00, 1'b0);
  endfunction
  function automatic exp_t jp_e(int iw, logic [1:0] pcs, logic link);
    return ex(3 + iw, 4'b0000, 1'b0, 1'b0, link ? 1 : 0, link ? 2'b10 : 2'b00,
              link ? 2'b10 : 2'b00, 1, pcs, 0, 0, 2'b00, 1'b0);
  endfunction

  // Memory responders: ready rises after iwait/dwait request cycles.
  int iwait = 0;
  int dwait = 0;

  initial begin
    int cnt;
    imem_ready = 1'b0;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (!imem_req) begin imem_ready = 1'b0; cnt = 0; end
      else if (!imem_ready) begin
        if (cnt >= iwait) imem_ready = 1'b1;
        else cnt++;
      end
    end
  end

  initial begin
    int cnt;
    dmem_ready = 1'b0;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (!dmem_req) begin dmem_ready = 1'b0; cnt = 0; end
      else if (!dmem_ready) begin
        if (cnt >= dwait) dmem_ready = 1'b1;
        else cnt++;
      end
    end
  end

  // Monitor: accumulates activity per instruction, compares on retire.
  int done_cnt = 0;

  initial begin
    int cyc, start, ir_cyc;
    int m_nreg, m_npc, m_nmw, m_ndr, m_bad;
    logic [3:0] m_aop;
    logic m_asrc, m_msg;
    logic [1:0] m_rd, m_m2r, m_pcs, m_msz;
    logic [31:0] prev_ret;
    bit busy;
    exp_t e;
    string tg;
    cyc = 0; start = 0; ir_cyc = -10; busy = 0; prev_ret = '0;
    m_nreg = 0; m_npc = 0; m_nmw = 0; m_ndr = 0; m_bad = 0;
    m_aop = '0; m_asrc = 0; m_msg = 0; m_rd = '0; m_m2r = '0; m_pcs = '0; m_msz = '0;
    forever begin
      @(negedge clk); #2;
      cyc++;
      if (rst) begin
        busy = 0;
        prev_ret = '0;
      end else begin
        if (retired != prev_ret) begin
          prev_ret = retired;
          if (expq.size() == 0) begin
            check_eq("sb_underflow", 32'(expq.size()), 32'd1);
          end else begin
            e  = expq.pop_front();
            tg = tagq.pop_front();
            check_eq({tg, ".lat"}, 32'(cyc - start), 32'(e.lat));
            if (e.chk_alu) begin
              check_eq({tg, ".ALUOp"}, 32'(m_aop), 32'(e.aop));
              check_eq({tg, ".ALUSrc"}, 32'(m_asrc), 32'(e.asrc));
            end
            check_eq({tg, ".nregWrite"}, 32'(m_nreg), 32'(e.nreg));
            check_eq({tg, ".regDst"}, 32'(m_rd), 32'(e.rd));
            check_eq({tg, ".memToReg"}, 32'(m_m2r), 32'(e.m2r));
            check_eq({tg, ".npc_write"}, 32'(m_npc), 32'(e.npc));
            check_eq({tg, ".PCSrc"}, 32'(m_pcs), 32'(e.pcs));
            check_eq({tg, ".nmemWrite"}, 32'(m_nmw), 32'(e.nmw));
            check_eq({tg, ".ndmem_req"}, 32'(m_ndr), 32'(e.ndr));
            check_eq({tg, ".mem_size"}, 32'(m_msz), 32'(e.msz));
            check_eq({tg, ".mem_signed"}, 32'(m_msg), 32'(e.msg));
            check_eq({tg, ".mem_alu"}, 32'(m_bad), 32'd0);
            done_cnt++;
          end
          busy = 0;
        end
        if (!busy && imem_req) begin
          busy = 1; start = cyc; ir_cyc = -10;
          m_nreg = 0; m_npc = 0; m_nmw = 0; m_ndr = 0; m_bad = 0;
          m_aop = '0; m_asrc = 0; m_msg = 0; m_rd = '0; m_m2r = '0; m_pcs = '0; m_msz = '0;
        end
        if (busy) begin
          if (ir_write) ir_cyc = cyc;
          if (cyc == ir_cyc + 2) begin m_aop = ALUOp; m_asrc = ALUSrc; end
          if (regWrite) begin m_nreg++; m_rd = regDst; m_m2r = memToReg; end
          if (pc_write && !ir_write) begin m_npc++; m_pcs = PCSrc; end
          if (memWrite) m_nmw++;
          if (dmem_req) begin
            m_ndr++; m_msz = mem_size; m_msg = mem_signed;
            if (ALUOp != 4'b0101 || !ALUSrc) m_bad++;
          end
        end
      end
    end
  end

  int exp_ret = 0;

  task automatic wait_ir(input string tg);
    bit got;
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk); #1;
      if (ir_write) got = 1;
    end
    if (!got) check_eq({tg, ".fetch_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic issue(input string tg, input logic [5:0] op, input logic [5:0] fn,
                       input int iw, input int dw, input logic cz, input exp_t e);
    int d0;
    @(posedge clk); #1;
    opcode = op; funct = fn; iwait = iw; dwait = dw; condZero = cz;
    expq.push_back(e); tagq.push_back(tg);
    exp_ret++;
    d0 = done_cnt;
    run = 1'b1;
    wait_ir(tg);
    @(posedge clk); #1;
    run = 1'b0;
    for (int i = 0; i < 100 && done_cnt == d0; i++) begin
      @(negedge clk); #3;
    end
    check_eq({tg, ".done"}, 32'(done_cnt - d0), 32'd1);
    check_eq({tg, ".retired"}, retired, 32'(exp_ret));
  endtask

  task automatic do_reset(input string tg);
    @(posedge clk); #1;
    rst = 1'b1; run = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_ret = 0;
    @(negedge clk); #1;
    check_eq({tg, ".rst_trap"}, 32'(trap), 32'd0);
    check_eq({tg, ".rst_retired"}, retired, 32'd0);
  endtask

  task automatic do_trap(input string tg, input logic [5:0] op, input logic [5:0] fn);
    int bad;
    @(posedge clk); #1;
    opcode = op; funct = fn; iwait = 0; dwait = 0;
    run = 1'b1;
    wait_ir(tg);
    @(posedge clk); #1;
    check_eq({tg, ".trap_in_decode"}, 32'(trap), 32'd0);
    @(posedge clk);
    @(negedge clk); #1;
    check_eq({tg, ".trap"}, 32'(trap), 32'd1);
    bad = 0;
    repeat (4) begin
      @(negedge clk); #1;
      if (imem_req || dmem_req || ir_write || pc_write || regWrite || memWrite || !trap) bad++;
    end
    check_eq({tg, ".trap_quiet"}, 32'(bad), 32'd0);
    do_reset(tg);
  endtask

  task automatic do_timeout(input string tg, input logic [5:0] op, input int iw,
                            input int dw, input int exp_ni, input int exp_nd);
    int ni, nd;
    @(posedge clk); #1;
    opcode = op; funct = 6'b000000; iwait = iw; dwait = dw;
    run = 1'b1;
    ni = 0; nd = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (trap) break;
      ni += int'(imem_req);
      nd += int'(dmem_req);
    end
    check_eq({tg, ".trap"}, 32'(trap), 32'd1);
    check_eq({tg, ".imem_req_cycles"}, 32'(ni), 32'(exp_ni));
    check_eq({tg, ".dmem_req_cycles"}, 32'(nd), 32'(exp_nd));
    do_reset(tg);
  endtask

  initial begin
    rst = 1'b1; run = 1'b1; condZero = 1'b0; opcode = '0; funct = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check_eq("in_rst.imem_req", 32'(imem_req), 32'd0);
    check_eq("in_rst.ir_write", 32'(ir_write), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; run = 1'b0;
    @(negedge clk); #1;
    check_eq("reset.retired", retired, 32'd0);
    check_eq("reset.trap", 32'(trap), 32'd0);
    check_eq("reset.strobes", 32'({imem_req, dmem_req, ir_write, pc_write, regWrite, memWrite}), 32'd0);

    // R-type ALU
    issue("addu",  6'b000000, 6'b100001, 0, 0, 1'b0, alu_e(0, 4'b0101, 1'b0, 2'b01));
    issue("subu",  6'b000000, 6'b100011, 1, 0, 1'b0, alu_e(1, 4'b0110, 1'b0, 2'b01));
    issue("and",   6'b000000, 6'b100100, 0, 0, 1'b0, alu_e(0, 4'b0001, 1'b0, 2'b01));
    issue("or",    6'b000000, 6'b100101, 0, 0, 1'b0, alu_e(0, 4'b0011, 1'b0, 2'b01));
    issue("xor",   6'b000000, 6'b100110, 2, 0, 1'b0, alu_e(2, 4'b0010, 1'b0, 2'b01));
    issue("sltu",  6'b000000, 6'b101011, 0, 0, 1'b0, alu_e(0, 4'b1000, 1'b0, 2'b01));
    issue("slt",   6'b000000, 6'b101010, 0, 0, 1'b0, alu_e(0, 4'b1001, 1'b0, 2'b01));
    issue("sll",   6'b000000, 6'b000000, 0, 0, 1'b0, alu_e(0, 4'b1010, 1'b0, 2'b01));
    issue("srl",   6'b000000, 6'b000010, 0, 0, 1'b0, alu_e(0, 4'b1011, 1'b0, 2'b01));
    issue("sub",   6'b000000, 6'b100010, 0, 0, 1'b0, alu_e(0, 4'b0110, 1'b0, 2'b01));
    // I-type ALU
    issue("addiu", 6'b001001, 6'b101010, 0, 0, 1'b0, alu_e(0, 4'b0101, 1'b1, 2'b00));
    issue("andi",  6'b001100, 6'b000000, 0, 0, 1'b0, alu_e(0, 4'b0001, 1'b1, 2'b00));
    issue("ori",   6'b001101, 6'b000000, 1, 0, 1'b0, alu_e(1, 4'b0011, 1'b1, 2'b00));
    issue("slti",  6'b001010, 6'b000000, 0, 0, 1'b0, alu_e(0, 4'b1001, 1'b1, 2'b00));
    issue("sltiu", 6'b001011, 6'b000000, 0, 0, 1'b0, alu_e(0, 4'b1000, 1'b1, 2'b00));
    issue("lui",   6'b001111, 6'b000000, 0, 0, 1'b0, alu_e(0, 4'b1100, 1'b1, 2'b00));
    // loads / stores
    issue("lw",    6'b100011, 6'b000000, 0, 3, 1'b0, ld_e(0, 3, 2'b00, 1'b0));
    issue("lbu",   6'b100100, 6'b000000, 0, 1, 1'b0, ld_e(0, 1, 2'b10, 1'b0));
    issue("lhu",   6'b100101, 6'b000000, 2, 0, 1'b0, ld_e(2, 0, 2'b01, 1'b0));
    issue("lb",    6'b100000, 6'b000000, 0, 0, 1'b0, ld_e(0, 0, 2'b10, 1'b1));
    issue("lh",    6'b100001, 6'b000000, 0, 2, 1'b0, ld_e(0, 2, 2'b01, 1'b1));
    issue("sw",    6'b101011, 6'b000000, 1, 2, 1'b0, st_e(1, 2, 2'b00));
    issue("sb",    6'b101000, 6'b000000, 0, 0, 1'b0, st_e(0, 0, 2'b10));
    issue("sh",    6'b101001, 6'b000000, 0, 1, 1'b0, st_e(0, 1, 2'b01));
    // branches and jumps
    issue("beq_t", 6'b000100, 6'b000000, 0, 0, 1'b1, br_e(0, 1'b1));
    issue("beq_n", 6'b000100, 6'b000000, 0, 0, 1'b0, br_e(0, 1'b0));
    issue("bne_t", 6'b000101, 6'b000000, 1, 0, 1'b0, br_e(1, 1'b1));
    issue("bne_n", 6'b000101, 6'b000000, 0, 0, 1'b1, br_e(0, 1'b0));
    issue("j",     6'b000010, 6'b000000, 0, 0, 1'b0, jp_e(0, 2'b01, 1'b0));
    issue("jal",   6'b000011, 6'b000000, 0, 0, 1'b0, jp_e(0, 2'b01, 1'b1));
    issue("jr",    6'b000000, 6'b001000, 1, 0, 1'b0, jp_e(1, 2'b10, 1'b0));

    // traps
    do_trap("bad_op", 6'b111111, 6'b000000);
    do_trap("bad_funct", 6'b000000, 6'b000001);
    do_timeout("dmem_to", 6'b101011, 0, 1000, 1, 16);
    do_timeout("imem_to", 6'b000000, 1000, 0, 16, 0);

    // normal operation after recovery from trap
    issue("addu2", 6'b000000, 6'b100001, 0, 0, 1'b0, alu_e(0, 4'b0101, 1'b0, 2'b01));

    check_eq("sb_empty", 32'(expq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
